// File: rtl/spi_stream_arbiter.sv
// Round-robin frame scheduler sharing one 16-bit FIFO write port between N_SRC sample sources.
// Each frame is HEADER, {grant, frame_seq}, then FRAME_LEN data words from the granted source.
module spi_stream_arbiter #(
   parameter int          N_SRC     = 4,
   parameter int          FRAME_LEN = 8,
   parameter logic [15:0] HEADER    = 16'hC691
) (
   input  logic                  dataclk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  fifo_overflow,
   input  logic [N_SRC-1:0]      src_valid,
   input  logic [16*N_SRC-1:0]   src_data,
   output logic [N_SRC-1:0]      src_ready,
   output logic [15:0]           out_data,
   output logic                  out_wen,
   output logic                  halted,
   output logic [7:0]            frame_seq
);

   localparam int         GW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ID,
      S_DATA,
      S_HALT
   } state_t;

   state_t        r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last_grant;
   logic [7:0]    r_count;
   logic [15:0]   r_out_data;
   logic          r_out_wen;
   logic          r_halted;
   logic [7:0]    r_frame_seq;

   logic          w_found;
   logic [GW-1:0] w_pick;
   logic [GW:0]   w_sum;
   logic [GW:0]   w_idx;
   logic [15:0]   w_word;
   logic          w_xfer;

   // Lowest offset from last_grant+1 wins, so scan from the far end and let nearer hits overwrite.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = N_SRC; i >= 1; i--) begin
         w_sum = {1'b0, r_last_grant} + (GW+1)'(i);
         w_idx = (w_sum >= (GW+1)'(N_SRC)) ? w_sum - (GW+1)'(N_SRC) : w_sum;
         if (src_valid[w_idx[GW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      src_ready = '0;
      if (r_state == S_DATA && enable && !fifo_overflow) begin
         src_ready[r_grant] = 1'b1;
      end
   end

   assign w_word = src_data[{r_grant, 4'b0000} +: 16];
   assign w_xfer = |(src_ready & src_valid);

   // NOTE: all state here is sequential, so every assignment is non-blocking.
   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= GW'(N_SRC - 1);
         r_count      <= '0;
         r_out_data   <= '0;
         r_out_wen    <= 1'b0;
         r_halted     <= 1'b0;
         r_frame_seq  <= '0;
      end else if (!enable && r_state != S_IDLE) begin
         r_state   <= S_IDLE;
         r_out_wen <= 1'b0;
         r_halted  <= 1'b0;
         r_count   <= '0;
      end else if (fifo_overflow &&
                   (r_state == S_ARB || r_state == S_ID || r_state == S_DATA)) begin
         r_state   <= S_HALT;
         r_out_wen <= 1'b0;
         r_halted  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out_wen <= 1'b0;
               if (enable) r_state <= S_ARB;
            end
            // A header never directly follows a data word: one turnaround cycle separates frames.
            S_ARB: begin
               if (w_found && !r_out_wen) begin
                  r_grant      <= w_pick;
                  r_last_grant <= w_pick;
                  r_out_data   <= HEADER;
                  r_out_wen    <= 1'b1;
                  r_state      <= S_ID;
               end else begin
                  r_out_wen <= 1'b0;
               end
            end
            S_ID: begin
               r_out_data  <= {8'(r_grant), r_frame_seq};
               r_out_wen   <= 1'b1;
               r_frame_seq <= r_frame_seq + 8'd1;
               r_count     <= '0;
               r_state     <= S_DATA;
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_out_data <= w_word;
                  r_out_wen  <= 1'b1;
                  r_count    <= r_count + 8'd1;
                  if (r_count == LAST_IDX) r_state <= S_ARB;
               end else begin
                  r_out_wen <= 1'b0;
               end
            end
            S_HALT: begin
               r_out_wen <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_out_wen <= 1'b0;
            end
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_wen   = r_out_wen;
   assign halted    = r_halted;
   assign frame_seq = r_frame_seq;

endmodule
